snoop_bus_controller: RTL and testbench
=======================================

Name: snoop_bus_controller

Overview:
- Parametrised successor to the 4-CPU MESI shared-bus glue: a single-outstanding-transaction snoop bus controller for NUM_CPUS private caches.
- Arbitrates cache miss/upgrade/writeback requests round-robin, broadcasts one snoop per transaction and collects per-cache snoop responses.
- Sources the line from a dirty peer cache (cache-to-cache transfer) or from main memory, then completes to the requester.
- Adds what the previous generation lacks: selectable MESI/MOESI mode (Owned state, no writeback on shared dirty read), snoop-ack timeout, protocol-error flag.

Parameters:
- NUM_CPUS, 4, number of cache ports (2..16)
- ADDR_WIDTH, 32, byte address width
- LINE_BITS, 256, cache line width in bits
- MOESI_EN, 1, 1 = dirty supplier keeps Owned and memory is not updated on BusRd; 0 = MESI, supplier writes back
- SNOOP_TIMEOUT, 15, cycles to wait for all snoop acks before forcing completion
- SRC_W (derived), $clog2(NUM_CPUS)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- req_valid  in  NUM_CPUS  per-CPU request, held until its resp_valid
- req_type  in  2*NUM_CPUS  00 BusRd, 01 BusRdX, 10 BusUpgr, 11 WriteBack
- req_addr  in  ADDR_WIDTH*NUM_CPUS  line address, low 5 bits ignored
- req_wdata  in  LINE_BITS*NUM_CPUS  writeback line
- snoop_valid  out  1  snoop broadcast active
- snoop_type  out  2  copy of granted req_type
- snoop_addr  out  ADDR_WIDTH  line-aligned address
- snoop_src  out  SRC_W  requester index; that cache must not respond
- snoop_ack  in  NUM_CPUS  snoop response valid (level)
- snoop_shared  in  NUM_CPUS  responder holds the line valid
- snoop_dirty  in  NUM_CPUS  responder holds M/O and supplies data
- snoop_data  in  LINE_BITS*NUM_CPUS  supplied line
- resp_valid  out  NUM_CPUS  one-cycle completion pulse to requester
- resp_data  out  LINE_BITS  fill line, valid with resp_valid
- resp_shared  out  1  1 = install S, 0 = install E (BusRd) / M (BusRdX, BusUpgr)
- mem_read, mem_write  out  1  memory request levels, held until mem_ready
- mem_addr  out  ADDR_WIDTH  line-aligned memory address
- mem_wdata  out  LINE_BITS  writeback data
- mem_rdata  in  LINE_BITS  memory line
- mem_ready  in  1  memory completion (one cycle)
- busy  out  1  FSM not IDLE
- proto_err  out  1  sticky: multiple dirty responders or snoop timeout

Behaviour:
- Reset: all outputs 0, FSM IDLE, round-robin pointer 0, proto_err cleared. Reset in any state aborts the transaction with no resp_valid pulse.
- All outputs are registered. FSM states: IDLE, SNOOP, MEM_RD, MEM_WR, RESP.
- IDLE:
  - On any req_valid, grant the first requester at or after pointer+1 (mod NUM_CPUS).
  - Latch index, type, address (low 5 bits zeroed) and wdata; set pointer = grant.
  - WriteBack goes to MEM_WR; all other types go to SNOOP.
- SNOOP:
  - snoop_valid held high; wait until snoop_ack is high for every index except snoop_src; a requester's own ack is ignored.
  - Latch OR of snoop_shared and all snoop_dirty bits. Data comes from the lowest-indexed dirty responder.
  - More than one dirty bit set sets proto_err.
  - Timeout: if acks are incomplete after SNOOP_TIMEOUT cycles, set proto_err, treat missing responders as clean and proceed.
  - Exit next cycle:
    - BusUpgr -> RESP, resp_shared=0.
    - Dirty hit on BusRdX -> RESP with peer data (ownership moves).
    - Dirty hit on BusRd with MOESI_EN=1 -> RESP with peer data.
    - Dirty hit on BusRd with MOESI_EN=0 -> MEM_WR with peer data, then RESP.
    - Clean -> MEM_RD.
- MEM_RD: mem_read high until mem_ready; capture mem_rdata; -> RESP.
- MEM_WR: mem_write high until mem_ready. Exits to IDLE for WriteBack, to RESP otherwise.
- RESP / WriteBack completion:
  - resp_valid[src] pulses one cycle with resp_data; next state IDLE.
  - WriteBack also completes with a resp_valid pulse, issued from MEM_WR.
  - resp_shared = any shared or dirty responder, and the type is BusRd.
- Minimum latency, BusUpgr with acks ready: grant cycle 0, snoop_valid cycles 1..1+, resp_valid at cycle 3.
- Requester dropping req_valid mid-transaction does not abort; the pulse is still issued. mem_ready outside a MEM state is ignored.
- Requests arriving while busy wait; no request is lost; fairness is strict round-robin.

Decomposition:
- coherence_pkg: request-type encodings, FSM state enum, MESI/MOESI line-state codes (I,S,E,O,M), resp_shared semantics.
- Sub-module rr_arbiter (parametrised NUM_CPUS, one-hot grant, pointer update on accept).

Test Plan:
- CPU0 BusRd 0x1000, no dirty/shared acks, memory returns line {8{32'h80}} -> one mem_read at 0x1000, resp_valid[0] with that line, resp_shared=0.
- CPU1 BusRd 0x1000 with cache0 acking shared=1, dirty=0 -> mem_read issued, resp_shared=1.
- CPU1 BusRd 0x1000 with cache0 dirty supplying 32'hDEADBEEF line:
  - MOESI_EN=1: resp_data = that line, no mem_write.
  - MOESI_EN=0: mem_write of that line precedes resp_valid[1].
- CPU0..CPU3 all request in the same cycle after reset -> grants in order 1,2,3,0; each gets exactly one resp_valid.
- CPU2 BusUpgr 0x7000, cache3 never acks -> after 15 SNOOP cycles proto_err=1, resp_valid[2] with resp_shared=0.
- CPU2 WriteBack 0x6000 of 32'hCAFEBABE line -> no snoop_valid, mem_write with that data; assert rst mid-MEM_WR -> all outputs 0, no resp pulse.

Source files
------------

// File: rtl/coherence_pkg.sv
// Shared definitions for the snoop bus controller: bus request encodings,
// controller FSM states, cache line states and fill-state semantics.
package coherence_pkg;

  // Bus request encodings carried on req_type / snoop_type
  typedef enum logic [1:0] {
    REQ_BUSRD     = 2'b00,
    REQ_BUSRDX    = 2'b01,
    REQ_BUSUPGR   = 2'b10,
    REQ_WRITEBACK = 2'b11
  } req_type_e;

  // Controller FSM states
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SNOOP  = 3'd1,
    ST_MEM_RD = 3'd2,
    ST_MEM_WR = 3'd3,
    ST_RESP   = 3'd4
  } bus_state_e;

  // Line states held by the private caches (O only exists in MOESI mode)
  typedef enum logic [2:0] {
    LS_I = 3'd0,
    LS_S = 3'd1,
    LS_E = 3'd2,
    LS_O = 3'd3,
    LS_M = 3'd4
  } line_state_e;

  // Lines are 32 bytes; the low address bits select a byte within the line
  localparam int LINE_OFFSET_BITS = 5;

  // resp_shared = 1 tells the requester to install S. Only a BusRd can end
  // shared; BusRdX/BusUpgr always install M and a clean BusRd installs E.
  function automatic logic resp_shared_f(input req_type_e t, input logic any_holder);
    return any_holder && (t == REQ_BUSRD);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first requester after the last winner and
// moves its pointer only when the grant is actually taken.
module rr_arbiter #(
  parameter int NUM_CPUS = 4,
  parameter int SRC_W    = $clog2(NUM_CPUS)
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic [NUM_CPUS-1:0] i_req,
  input  logic                i_accept,
  output logic [NUM_CPUS-1:0] o_grant_oh,
  output logic [SRC_W-1:0]    o_grant_idx,
  output logic                o_grant_valid
);

  logic [SRC_W-1:0] r_ptr;

  // Search from pointer+1 upward; descending loop lets the nearest offset win
  always_comb begin
    o_grant_oh    = '0;
    o_grant_idx   = '0;
    o_grant_valid = 1'b0;
    for (int k = NUM_CPUS; k >= 1; k--) begin
      int idx;
      idx = (int'(r_ptr) + k) % NUM_CPUS;
      if (i_req[idx]) begin
        o_grant_oh    = NUM_CPUS'(1) << idx;
        o_grant_idx   = SRC_W'(idx);
        o_grant_valid = 1'b1;
      end else begin
        o_grant_valid = o_grant_valid;
      end
    end
  end

  // Last-winner pointer, updated when the controller accepts the grant
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ptr <= '0;
    end else if (i_accept && o_grant_valid) begin
      r_ptr <= o_grant_idx;
    end else begin
      r_ptr <= r_ptr;
    end
  end

endmodule

// File: rtl/snoop_bus_controller.sv
// Single-outstanding-transaction snoop bus controller for NUM_CPUS private
// caches: round-robin arbitration, snoop broadcast/collection, cache-to-cache
// or memory sourcing, and a one-cycle completion pulse to the requester.
module snoop_bus_controller
  import coherence_pkg::*;
#(
  parameter  int NUM_CPUS      = 4,
  parameter  int ADDR_WIDTH    = 32,
  parameter  int LINE_BITS     = 256,
  parameter  int MOESI_EN      = 1,
  parameter  int SNOOP_TIMEOUT = 15,
  localparam int SRC_W         = $clog2(NUM_CPUS)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_CPUS-1:0]            req_valid,
  input  logic [2*NUM_CPUS-1:0]          req_type,
  input  logic [ADDR_WIDTH*NUM_CPUS-1:0] req_addr,
  input  logic [LINE_BITS*NUM_CPUS-1:0]  req_wdata,
  output logic                           snoop_valid,
  output logic [1:0]                     snoop_type,
  output logic [ADDR_WIDTH-1:0]          snoop_addr,
  output logic [SRC_W-1:0]               snoop_src,
  input  logic [NUM_CPUS-1:0]            snoop_ack,
  input  logic [NUM_CPUS-1:0]            snoop_shared,
  input  logic [NUM_CPUS-1:0]            snoop_dirty,
  input  logic [LINE_BITS*NUM_CPUS-1:0]  snoop_data,
  output logic [NUM_CPUS-1:0]            resp_valid,
  output logic [LINE_BITS-1:0]           resp_data,
  output logic                           resp_shared,
  output logic                           mem_read,
  output logic                           mem_write,
  output logic [ADDR_WIDTH-1:0]          mem_addr,
  output logic [LINE_BITS-1:0]           mem_wdata,
  input  logic [LINE_BITS-1:0]           mem_rdata,
  input  logic                           mem_ready,
  output logic                           busy,
  output logic                           proto_err
);

  localparam int TMR_W = $clog2(SNOOP_TIMEOUT + 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(SNOOP_TIMEOUT - 1);
  localparam logic [ADDR_WIDTH-1:0] LINE_MASK =
    {{(ADDR_WIDTH-LINE_OFFSET_BITS){1'b1}}, {LINE_OFFSET_BITS{1'b0}}};

  bus_state_e            r_state;
  req_type_e             r_type;
  logic [NUM_CPUS-1:0]   r_src_oh;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [LINE_BITS-1:0]  r_line;
  logic                  r_any_holder;
  logic [TMR_W-1:0]      r_timer;

  logic [NUM_CPUS-1:0]   w_grant_oh;
  logic [SRC_W-1:0]      w_grant_idx;
  logic                  w_grant_valid;
  logic                  w_accept;
  req_type_e             w_req_type;
  logic [ADDR_WIDTH-1:0] w_req_addr;
  logic [LINE_BITS-1:0]  w_req_wdata;
  logic [NUM_CPUS-1:0]   w_resp_mask;
  logic [NUM_CPUS-1:0]   w_dirty;
  logic [NUM_CPUS-1:0]   w_shared;
  logic                  w_all_acked;
  logic                  w_multi_dirty;
  logic [LINE_BITS-1:0]  w_peer_data;

  // A requester whose pulse is on the bus this cycle is hidden from the
  // arbiter so a still-held req_valid cannot be granted a second time.
  rr_arbiter #(.NUM_CPUS(NUM_CPUS), .SRC_W(SRC_W)) u_arb (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_req        (req_valid & ~resp_valid),
    .i_accept     (w_accept),
    .o_grant_oh   (w_grant_oh),
    .o_grant_idx  (w_grant_idx),
    .o_grant_valid(w_grant_valid)
  );

  assign w_accept = (r_state == ST_IDLE) && w_grant_valid;

  // Select the granted requester's type, aligned address and writeback line
  always_comb begin
    w_req_type  = req_type_e'(req_type[int'(w_grant_idx)*2 +: 2]);
    w_req_addr  = req_addr[int'(w_grant_idx)*ADDR_WIDTH +: ADDR_WIDTH] & LINE_MASK;
    w_req_wdata = req_wdata[int'(w_grant_idx)*LINE_BITS +: LINE_BITS];
  end

  // Snoop collection: requester's own ack is ignored, missing acks count as clean
  always_comb begin
    w_resp_mask   = snoop_ack & ~r_src_oh;
    w_all_acked   = &(snoop_ack | r_src_oh);
    w_dirty       = snoop_dirty & w_resp_mask;
    w_shared      = snoop_shared & w_resp_mask;
    w_multi_dirty = |(w_dirty & (w_dirty - NUM_CPUS'(1)));
    w_peer_data   = '0;
    for (int i = NUM_CPUS - 1; i >= 0; i--) begin
      if (w_dirty[i]) begin
        w_peer_data = snoop_data[i*LINE_BITS +: LINE_BITS];
      end else begin
        w_peer_data = w_peer_data;
      end
    end
  end

  // Transaction FSM with all bus-visible outputs registered
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_type       <= REQ_BUSRD;
      r_src_oh     <= '0;
      r_addr       <= '0;
      r_line       <= '0;
      r_any_holder <= 1'b0;
      r_timer      <= '0;
      snoop_valid  <= 1'b0;
      snoop_type   <= 2'b00;
      snoop_addr   <= '0;
      snoop_src    <= '0;
      resp_valid   <= '0;
      resp_data    <= '0;
      resp_shared  <= 1'b0;
      mem_read     <= 1'b0;
      mem_write    <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      busy         <= 1'b0;
      proto_err    <= 1'b0;
    end else begin
      resp_valid <= '0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_type    <= w_req_type;
            r_src_oh  <= w_grant_oh;
            r_addr    <= w_req_addr;
            snoop_src <= w_grant_idx;
            busy      <= 1'b1;
            r_timer   <= '0;
            if (w_req_type == REQ_WRITEBACK) begin
              r_state   <= ST_MEM_WR;
              mem_write <= 1'b1;
              mem_addr  <= w_req_addr;
              mem_wdata <= w_req_wdata;
            end else begin
              r_state     <= ST_SNOOP;
              snoop_valid <= 1'b1;
              snoop_type  <= w_req_type;
              snoop_addr  <= w_req_addr;
            end
          end
        end
        ST_SNOOP: begin
          if (w_all_acked || (r_timer == TMR_LAST)) begin
            snoop_valid  <= 1'b0;
            r_any_holder <= (|w_shared) || (|w_dirty);
            r_line       <= w_peer_data;
            if (!w_all_acked || w_multi_dirty) begin
              proto_err <= 1'b1;
            end
            if (r_type == REQ_BUSUPGR) begin
              r_state <= ST_RESP;
            end else if ((|w_dirty) && (r_type == REQ_BUSRDX || MOESI_EN != 0)) begin
              r_state <= ST_RESP;
            end else if (|w_dirty) begin
              // MESI: the dirty supplier drops to S, so memory must be updated
              r_state   <= ST_MEM_WR;
              mem_write <= 1'b1;
              mem_addr  <= r_addr;
              mem_wdata <= w_peer_data;
            end else begin
              r_state  <= ST_MEM_RD;
              mem_read <= 1'b1;
              mem_addr <= r_addr;
            end
          end else begin
            r_timer <= r_timer + TMR_W'(1);
          end
        end
        ST_MEM_RD: begin
          if (mem_ready) begin
            mem_read <= 1'b0;
            r_line   <= mem_rdata;
            r_state  <= ST_RESP;
          end
        end
        ST_MEM_WR: begin
          if (mem_ready) begin
            mem_write <= 1'b0;
            if (r_type == REQ_WRITEBACK) begin
              resp_valid  <= r_src_oh;
              resp_data   <= '0;
              resp_shared <= 1'b0;
              busy        <= 1'b0;
              r_state     <= ST_IDLE;
            end else begin
              r_state <= ST_RESP;
            end
          end
        end
        ST_RESP: begin
          resp_valid  <= r_src_oh;
          resp_data   <= r_line;
          resp_shared <= resp_shared_f(r_type, r_any_holder);
          busy        <= 1'b0;
          r_state     <= ST_IDLE;
        end
        default: begin
          busy    <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_snoop_bus_controller.sv
// Directed self-checking bench for snoop_bus_controller. dut_a runs in MOESI
// mode, dut_b in MESI mode; they share every input except req_valid.
module tb_snoop_bus_controller;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int LB = 256;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [N-1:0]    req_valid_a, req_valid_b;
  logic [2*N-1:0]  req_type;
  logic [AW*N-1:0] req_addr;
  logic [LB*N-1:0] req_wdata, snoop_data;
  logic [N-1:0]    snoop_ack, snoop_shared, snoop_dirty;
  logic [LB-1:0]   mem_rdata;
  logic            mem_ready;

  logic          snoop_valid_a, snoop_valid_b, resp_shared_a, resp_shared_b;
  logic [1:0]    snoop_type_a, snoop_type_b, snoop_src_a, snoop_src_b;
  logic [AW-1:0] snoop_addr_a, snoop_addr_b, mem_addr_a, mem_addr_b;
  logic [N-1:0]  resp_valid_a, resp_valid_b;
  logic [LB-1:0] resp_data_a, resp_data_b, mem_wdata_a, mem_wdata_b;
  logic          mem_read_a, mem_read_b, mem_write_a, mem_write_b;
  logic          busy_a, busy_b, proto_err_a, proto_err_b;

  snoop_bus_controller #(.NUM_CPUS(N), .ADDR_WIDTH(AW), .LINE_BITS(LB), .MOESI_EN(1), .SNOOP_TIMEOUT(15)) dut_a (
    .clk(clk), .rst(rst), .req_valid(req_valid_a), .req_type(req_type), .req_addr(req_addr),
    .req_wdata(req_wdata), .snoop_valid(snoop_valid_a), .snoop_type(snoop_type_a),
    .snoop_addr(snoop_addr_a), .snoop_src(snoop_src_a), .snoop_ack(snoop_ack),
    .snoop_shared(snoop_shared), .snoop_dirty(snoop_dirty), .snoop_data(snoop_data),
    .resp_valid(resp_valid_a), .resp_data(resp_data_a), .resp_shared(resp_shared_a),
    .mem_read(mem_read_a), .mem_write(mem_write_a), .mem_addr(mem_addr_a),
    .mem_wdata(mem_wdata_a), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .busy(busy_a), .proto_err(proto_err_a)
  );

  snoop_bus_controller #(.NUM_CPUS(N), .ADDR_WIDTH(AW), .LINE_BITS(LB), .MOESI_EN(0), .SNOOP_TIMEOUT(15)) dut_b (
    .clk(clk), .rst(rst), .req_valid(req_valid_b), .req_type(req_type), .req_addr(req_addr),
    .req_wdata(req_wdata), .snoop_valid(snoop_valid_b), .snoop_type(snoop_type_b),
    .snoop_addr(snoop_addr_b), .snoop_src(snoop_src_b), .snoop_ack(snoop_ack),
    .snoop_shared(snoop_shared), .snoop_dirty(snoop_dirty), .snoop_data(snoop_data),
    .resp_valid(resp_valid_b), .resp_data(resp_data_b), .resp_shared(resp_shared_b),
    .mem_read(mem_read_b), .mem_write(mem_write_b), .mem_addr(mem_addr_b),
    .mem_wdata(mem_wdata_b), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .busy(busy_b), .proto_err(proto_err_b)
  );

  int checks = 0;
  int failures = 0;

  // Observation log filled by tick()
  int            cyc, nord, mrd_a, mwr_a, mwr_b, snoop_cnt_a, mwr_cyc_b, rcyc_b;
  int            rcnt_a[N];
  int            rcnt_b[N];
  int            order[8];
  logic [LB-1:0] rdata_a, rdata_b, mwr_data_a, mwr_data_b;
  logic          rsh_a;
  logic [AW-1:0] mrd_addr_a, mwr_addr_a;
  logic          mem_en;

  logic [LB-1:0] line_80, line_dead, line_cafe, line_5a;

  task automatic clear_log();
    cyc = 0; nord = 0; mrd_a = 0; mwr_a = 0; mwr_b = 0; snoop_cnt_a = 0;
    mwr_cyc_b = 0; rcyc_b = 0; rdata_a = '0; rdata_b = '0; rsh_a = 1'b0;
    mwr_data_a = '0; mwr_data_b = '0; mrd_addr_a = '0; mwr_addr_a = '0;
    for (int i = 0; i < N; i++) begin rcnt_a[i] = 0; rcnt_b[i] = 0; end
    for (int i = 0; i < 8; i++) order[i] = -1;
  endtask

  // One clock: observe outputs at negedge, drop satisfied requests, model memory
  task automatic tick();
    @(negedge clk);
    cyc++;
    for (int i = 0; i < N; i++) begin
      if (resp_valid_a[i]) begin
        rcnt_a[i]++; rdata_a = resp_data_a; rsh_a = resp_shared_a;
        if (nord < 8) order[nord] = i;
        nord++;
        req_valid_a[i] = 1'b0;
      end
      if (resp_valid_b[i]) begin
        rcnt_b[i]++; rdata_b = resp_data_b; rcyc_b = cyc;
        req_valid_b[i] = 1'b0;
      end
    end
    if (snoop_valid_a) snoop_cnt_a++;
    if (mem_ready) begin
      mem_ready = 1'b0;
    end else if (mem_en && (mem_read_a || mem_write_a || mem_read_b || mem_write_b)) begin
      mem_ready = 1'b1;
      if (mem_read_a) begin mrd_a++; mrd_addr_a = mem_addr_a; end
      if (mem_write_a) begin mwr_a++; mwr_addr_a = mem_addr_a; mwr_data_a = mem_wdata_a; end
      if (mem_write_b) begin mwr_b++; mwr_data_b = mem_wdata_b; mwr_cyc_b = cyc; end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid_a = '0; req_valid_b = '0; req_type = '0; req_addr = '0; req_wdata = '0;
    snoop_ack = '0; snoop_shared = '0; snoop_dirty = '0; snoop_data = '0;
    mem_rdata = '0; mem_ready = 1'b0; mem_en = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    clear_log();
  endtask

  task automatic set_req(input int cpu, input logic [1:0] t, input logic [AW-1:0] a,
                         input logic [LB-1:0] d, input bit on_b);
    req_type[2*cpu +: 2]   = t;
    req_addr[AW*cpu +: AW] = a;
    req_wdata[LB*cpu +: LB] = d;
    if (on_b) req_valid_b[cpu] = 1'b1;
    else      req_valid_a[cpu] = 1'b1;
  endtask

  // Tick until both controllers are idle with nothing pending, bounded
  task automatic wait_done(input string name);
    int n = 0;
    bit done = 1'b0;
    while (!done && n < 400) begin
      tick();
      n++;
      done = (req_valid_a == '0) && (req_valid_b == '0) && !busy_a && !busy_b &&
             (resp_valid_a == '0) && (resp_valid_b == '0);
    end
    checks++;
    if (!done) begin
      failures++;
      $display("FAIL %s_timeout: still busy after %0d cycles, expected completion", name, n);
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({snoop_valid_a, resp_valid_a, resp_shared_a, mem_read_a, mem_write_a, busy_a, proto_err_a} !== 10'b0) begin
      failures++;
      $display("FAIL reset_ctrl: got %b expected 0", {snoop_valid_a, resp_valid_a, resp_shared_a, mem_read_a, mem_write_a, busy_a, proto_err_a});
    end
    checks++;
    if ({mem_addr_a, snoop_addr_a, resp_data_a} !== '0) begin
      failures++;
      $display("FAIL reset_data: got %0h expected 0", {mem_addr_a, snoop_addr_a, resp_data_a});
    end
  endtask

  task automatic test_clean_read();
    do_reset();
    snoop_ack = 4'hF; mem_rdata = line_80;
    set_req(0, 2'b00, 32'h0000_101F, '0, 1'b0);
    wait_done("clean_read");
    checks++;
    if (mrd_a !== 1 || mrd_addr_a !== 32'h0000_1000) begin
      failures++; $display("FAIL clean_mem_read: got count %0d addr %0h expected 1 at 1000", mrd_a, mrd_addr_a);
    end
    checks++;
    if (rcnt_a[0] !== 1 || rdata_a !== line_80 || rsh_a !== 1'b0) begin
      failures++; $display("FAIL clean_resp: got cnt %0d sh %0b data %0h expected 1 0 %0h", rcnt_a[0], rsh_a, rdata_a, line_80);
    end
  endtask

  task automatic test_shared_read();
    do_reset();
    snoop_ack = 4'hF; snoop_shared = 4'b0001; mem_rdata = line_80;
    set_req(1, 2'b00, 32'h0000_1000, '0, 1'b0);
    wait_done("shared_read");
    checks++;
    if (mrd_a !== 1 || rcnt_a[1] !== 1 || rsh_a !== 1'b1 || rdata_a !== line_80) begin
      failures++; $display("FAIL shared_read: got rd %0d cnt %0d sh %0b expected 1 1 1", mrd_a, rcnt_a[1], rsh_a);
    end
  endtask

  task automatic test_dirty_moesi();
    do_reset();
    snoop_ack = 4'hF; snoop_shared = 4'b0001; snoop_dirty = 4'b0001;
    snoop_data[0 +: LB] = line_dead; mem_rdata = line_80;
    set_req(1, 2'b00, 32'h0000_1000, '0, 1'b0);
    wait_done("dirty_moesi");
    checks++;
    if (rdata_a !== line_dead || rcnt_a[1] !== 1 || rsh_a !== 1'b1) begin
      failures++; $display("FAIL moesi_data: got %0h sh %0b expected %0h sh 1", rdata_a, rsh_a, line_dead);
    end
    checks++;
    if (mrd_a !== 0 || mwr_a !== 0 || proto_err_a !== 1'b0) begin
      failures++; $display("FAIL moesi_no_mem: got rd %0d wr %0d perr %0b expected 0 0 0", mrd_a, mwr_a, proto_err_a);
    end
  endtask

  task automatic test_dirty_mesi();
    do_reset();
    snoop_ack = 4'hF; snoop_shared = 4'b0001; snoop_dirty = 4'b0001;
    snoop_data[0 +: LB] = line_dead; mem_rdata = line_80;
    set_req(1, 2'b00, 32'h0000_1000, '0, 1'b1);
    wait_done("dirty_mesi");
    checks++;
    if (mwr_b !== 1 || mwr_data_b !== line_dead || !(mwr_cyc_b < rcyc_b)) begin
      failures++; $display("FAIL mesi_writeback: got wr %0d at %0d resp at %0d expected 1 write before resp", mwr_b, mwr_cyc_b, rcyc_b);
    end
    checks++;
    if (rcnt_b[1] !== 1 || rdata_b !== line_dead) begin
      failures++; $display("FAIL mesi_resp: got cnt %0d data %0h expected 1 %0h", rcnt_b[1], rdata_b, line_dead);
    end
  endtask

  task automatic test_round_robin();
    int exp_ord[4] = '{1, 2, 3, 0};
    do_reset();
    snoop_ack = 4'hF; mem_rdata = line_80;
    for (int i = 0; i < N; i++) set_req(i, 2'b00, 32'h0000_2000 + 32'(i) * 32'h100, '0, 1'b0);
    wait_done("round_robin");
    checks++;
    if (nord !== 4) begin
      failures++; $display("FAIL rr_count: got %0d pulses expected 4", nord);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (order[i] !== exp_ord[i] || rcnt_a[i] !== 1) begin
        failures++; $display("FAIL rr_order%0d: got cpu %0d (cnt %0d) expected cpu %0d (cnt 1)", i, order[i], rcnt_a[i], exp_ord[i]);
      end
    end
  endtask

  task automatic test_upgr_latency();
    do_reset();
    snoop_ack = 4'hF;
    set_req(2, 2'b10, 32'h0000_7004, '0, 1'b0);
    tick();
    checks++;
    if (snoop_valid_a !== 1'b1 || snoop_src_a !== 2'd2 || snoop_type_a !== 2'b10 || snoop_addr_a !== 32'h0000_7000) begin
      failures++; $display("FAIL upgr_snoop: got v %0b src %0d type %0b addr %0h expected 1 2 10 7000", snoop_valid_a, snoop_src_a, snoop_type_a, snoop_addr_a);
    end
    tick();
    checks++;
    if (resp_valid_a !== 4'b0000 || snoop_valid_a !== 1'b0) begin
      failures++; $display("FAIL upgr_cycle2: got resp %b snoop %0b expected 0000 0", resp_valid_a, snoop_valid_a);
    end
    tick();
    checks++;
    if (resp_valid_a !== 4'b0100 || resp_shared_a !== 1'b0) begin
      failures++; $display("FAIL upgr_cycle3: got resp %b sh %0b expected 0100 0", resp_valid_a, resp_shared_a);
    end
    wait_done("upgr");
    checks++;
    if (mrd_a !== 0 || mwr_a !== 0) begin
      failures++; $display("FAIL upgr_no_mem: got rd %0d wr %0d expected 0 0", mrd_a, mwr_a);
    end
  endtask

  task automatic test_multi_dirty();
    do_reset();
    snoop_ack = 4'hF; snoop_dirty = 4'b0110;
    snoop_data[1*LB +: LB] = line_dead; snoop_data[2*LB +: LB] = line_5a;
    set_req(0, 2'b01, 32'h0000_3000, '0, 1'b0);
    wait_done("multi_dirty");
    checks++;
    if (rdata_a !== line_dead || rsh_a !== 1'b0 || rcnt_a[0] !== 1) begin
      failures++; $display("FAIL multi_dirty_data: got %0h sh %0b expected %0h sh 0", rdata_a, rsh_a, line_dead);
    end
    checks++;
    if (proto_err_a !== 1'b1 || mrd_a !== 0) begin
      failures++; $display("FAIL multi_dirty_err: got perr %0b rd %0d expected 1 0", proto_err_a, mrd_a);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    snoop_ack = 4'b0011;
    set_req(2, 2'b10, 32'h0000_7000, '0, 1'b0);
    wait_done("timeout");
    checks++;
    if (snoop_cnt_a !== 15) begin
      failures++; $display("FAIL timeout_cycles: got %0d snoop cycles expected 15", snoop_cnt_a);
    end
    checks++;
    if (proto_err_a !== 1'b1 || rcnt_a[2] !== 1 || rsh_a !== 1'b0) begin
      failures++; $display("FAIL timeout_resp: got perr %0b cnt %0d sh %0b expected 1 1 0", proto_err_a, rcnt_a[2], rsh_a);
    end
  endtask

  task automatic test_writeback_reset();
    do_reset();
    snoop_ack = 4'hF;
    set_req(2, 2'b11, 32'h0000_6000, line_cafe, 1'b0);
    wait_done("writeback");
    checks++;
    if (snoop_cnt_a !== 0 || mwr_a !== 1 || mwr_addr_a !== 32'h0000_6000 || mwr_data_a !== line_cafe) begin
      failures++; $display("FAIL wb_mem: got snoop %0d wr %0d addr %0h data %0h expected 0 1 6000 %0h", snoop_cnt_a, mwr_a, mwr_addr_a, mwr_data_a, line_cafe);
    end
    checks++;
    if (rcnt_a[2] !== 1) begin
      failures++; $display("FAIL wb_resp: got %0d pulses expected 1", rcnt_a[2]);
    end
    // Second writeback stalls in the memory write, then reset lands on it
    clear_log();
    mem_en = 1'b0;
    set_req(2, 2'b11, 32'h0000_6000, line_cafe, 1'b0);
    tick(); tick(); tick();
    checks++;
    if (mem_write_a !== 1'b1 || busy_a !== 1'b1) begin
      failures++; $display("FAIL wb_stall: got wr %0b busy %0b expected 1 1", mem_write_a, busy_a);
    end
    rst = 1'b1;
    req_valid_a = '0;
    tick();
    checks++;
    if ({snoop_valid_a, snoop_type_a, snoop_src_a, snoop_addr_a, resp_valid_a, resp_data_a, resp_shared_a,
         mem_read_a, mem_write_a, mem_addr_a, mem_wdata_a, busy_a, proto_err_a} !== '0) begin
      failures++; $display("FAIL wb_reset_outputs: got %0h expected 0",
        {snoop_valid_a, snoop_type_a, snoop_src_a, snoop_addr_a, resp_valid_a, resp_data_a, resp_shared_a,
         mem_read_a, mem_write_a, mem_addr_a, mem_wdata_a, busy_a, proto_err_a});
    end
    rst = 1'b0;
    mem_en = 1'b1;
    tick(); tick(); tick();
    checks++;
    if (rcnt_a[2] !== 0 || busy_a !== 1'b0 || mem_write_a !== 1'b0) begin
      failures++; $display("FAIL wb_abort: got pulses %0d busy %0b wr %0b expected 0 0 0", rcnt_a[2], busy_a, mem_write_a);
    end
  endtask

  initial begin
    line_80   = {8{32'h0000_0080}};
    line_dead = {8{32'hDEAD_BEEF}};
    line_cafe = {8{32'hCAFE_BABE}};
    line_5a   = {8{32'h5A5A_5A5A}};
    test_reset();
    test_clean_read();
    test_shared_read();
    test_dirty_moesi();
    test_dirty_mesi();
    test_round_robin();
    test_upgr_latency();
    test_multi_dirty();
    test_timeout();
    test_writeback_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
